// File: rtl/register_read_issue_pkg.sv
// Shared types for the register read/issue stage and the 16 x 4-bit register file write side.
// Optional hazard-stall statistics are enabled with the READER_STATS_EN macro.
package register_read_issue_pkg;

   localparam int REG_W = 4;
   localparam int NREG  = 16;
   localparam int IDX_W = 4;

   typedef logic [IDX_W-1:0] reg_idx_t;
   typedef logic [REG_W-1:0] reg_data_t;
   typedef logic [NREG-1:0]  load_bus_t;

endpackage

// File: rtl/register_read_issue_reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, cleared by write-back, set by issue.
// A set and a clear of the same bit in one cycle leaves it set (new producer in flight).
module reg_scoreboard
   import register_read_issue_pkg::*;
(
   input  logic      clock,
   input  logic      reset,
   input  logic      set_en,
   input  reg_idx_t  set_idx,
   input  load_bus_t clr,
   output load_bus_t busy
);

   load_bus_t set_mask;

   always_comb begin
      set_mask = '0;
      if (set_en) set_mask = load_bus_t'(1) << set_idx;
   end

   always_ff @(posedge clock) begin
      if (reset) busy <= '0;
      else       busy <= (busy & ~clr) | set_mask;
   end

endmodule

// File: rtl/register_read_issue.sv
// Register read/issue stage: operand select with write-back bypass, RAW/WAW stall on the
// scoreboard, and a registered valid/ready operand slot. READER_STATS_EN adds stall_cnt.
module register_read_issue
   import register_read_issue_pkg::*;
#(
   parameter int WIDTH = REG_W,
   parameter int NREG  = 16
`ifdef READER_STATS_EN
   ,
   parameter int CNT_W = 8
`endif
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NREG*WIDTH-1:0] q_all,
   input  load_bus_t             wb_load,
   input  logic [WIDTH-1:0]      wb_d,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  reg_idx_t              rs_a,
   input  reg_idx_t              rs_b,
   input  reg_idx_t              rd,
   input  logic                  rd_en,
   output logic                  op_valid,
   input  logic                  op_ready,
   output logic [WIDTH-1:0]      op_a,
   output logic [WIDTH-1:0]      op_b,
   output reg_idx_t              op_rd,
   output logic                  op_rd_en
`ifdef READER_STATS_EN
   ,
   output logic [CNT_W-1:0]      stall_cnt
`endif
);

   load_bus_t        busy;
   logic [WIDTH-1:0] val_a;
   logic [WIDTH-1:0] val_b;
   logic             hazard;
   logic             slot_free;
   logic             fire;

   // Write-back in the same cycle both bypasses the value and resolves the hazard.
   always_comb begin
      val_a     = wb_load[rs_a] ? wb_d : q_all[int'(rs_a)*WIDTH +: WIDTH];
      val_b     = wb_load[rs_b] ? wb_d : q_all[int'(rs_b)*WIDTH +: WIDTH];
      hazard    = (busy[rs_a] & ~wb_load[rs_a])
                | (busy[rs_b] & ~wb_load[rs_b])
                | (rd_en & busy[rd] & ~wb_load[rd]);
      slot_free = ~op_valid | op_ready;
      req_ready = slot_free & ~hazard;
      fire      = req_valid & req_ready;
   end

   reg_scoreboard u_sb (
      .clock   (clock),
      .reset   (reset),
      .set_en  (fire & rd_en),
      .set_idx (rd),
      .clr     (wb_load),
      .busy    (busy)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         op_valid <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         op_rd    <= '0;
         op_rd_en <= 1'b0;
      end else if (fire) begin
         op_valid <= 1'b1;
         op_a     <= val_a;
         op_b     <= val_b;
         op_rd    <= rd;
         op_rd_en <= rd_en;
      end else if (op_ready) begin
         op_valid <= 1'b0;
      end
   end

`ifdef READER_STATS_EN
   always_ff @(posedge clock) begin
      if (reset)
         stall_cnt <= '0;
      else if (req_valid & slot_free & hazard & ~&stall_cnt)
         stall_cnt <= stall_cnt + 1'b1;
   end
`endif

endmodule

// File: doc/register_read_issue.md
Name: register_read_issue

Overview:
- Read-side companion to the 16 x 4-bit general-purpose register file.
- Accepts decoded instructions and selects two source operands from the register outputs.
- Forwards write-back data issued in the same cycle.
- Tracks pending destination writes in a 16-bit scoreboard, stalls on RAW/WAW hazards, and hands operands to execute through a registered valid/ready stage.

Parameters:
- WIDTH, 4, register data width
- NREG, 16, number of registers (fixed; index width 4)
- CNT_W, 8, width of stall counter (optional feature only)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- q_all  in  64  all register outputs, register n at bits [4n+3:4n]
- wb_load  in  16  one-hot write enable driven to the register file (same encoding as its load bus)
- wb_d  in  4  write data driven to the register file
- req_valid  in  1  decode has an instruction
- req_ready  out  1  stage accepts the instruction this cycle
- rs_a  in  4  source A index
- rs_b  in  4  source B index
- rd  in  4  destination index
- rd_en  in  1  instruction writes rd
- op_valid  out  1  operand bundle valid to execute
- op_ready  in  1  execute accepts the bundle
- op_a  out  4  operand A
- op_b  out  4  operand B
- op_rd  out  4  registered destination index
- op_rd_en  out  1  registered destination enable
- stall_cnt  out  CNT_W  saturating hazard-stall count (only with READER_STATS_EN)

Behaviour:
- Reset: op_valid, op_a, op_b, op_rd, op_rd_en = 0; scoreboard busy[15:0] = 0; stall_cnt = 0. reset overrides all other events in that cycle.
- Source value for src in {a,b}:
  - If wb_load[rs_src] = 1, the value is wb_d (bypass).
  - Otherwise the value is q_all[4*rs_src +: 4].
- Hazard:
  - hz_a = busy[rs_a] & ~wb_load[rs_a]
  - hz_b = busy[rs_b] & ~wb_load[rs_b]
  - hz_d = rd_en & busy[rd] & ~wb_load[rd]
  - hazard = hz_a | hz_b | hz_d. Sources are always checked; no per-instruction source-enable.
- Output slot free: slot_free = ~op_valid | op_ready.
- req_ready = slot_free & ~hazard. This is combinational and does not depend on req_valid.
- Issue (fire) = req_valid & req_ready. On fire:
  - op_valid <= 1; op_a and op_b <= source values; op_rd <= rd; op_rd_en <= rd_en.
  - If rd_en, set busy[rd].
  - Latency is 1 cycle from fire to op_valid.
- If there is no fire and op_ready & op_valid: op_valid <= 0. op_a, op_b, op_rd and op_rd_en hold their values.
- While op_valid & ~op_ready: all op_* outputs hold stable and req_ready = 0.
- Scoreboard clear: every bit n with wb_load[n] = 1 clears busy[n], including when multiple bits are hot.
- Same-cycle set and clear of the same bit: set wins. The new producer is in flight.
- busy only changes on fire or on write-back.
- Held operands are snapshots. A write-back arriving while the bundle is held does not update op_a or op_b; the scoreboard guarantees this is never a needed value.
- rs_a = rs_b is legal; both operands receive the same value.
- rd equal to a source is legal; sources read the pre-issue value.

Optional Feature:
- Macro: READER_STATS_EN.
- Defined:
  - stall_cnt increments by 1 each cycle with req_valid & slot_free & hazard.
  - stall_cnt saturates at 2^CNT_W - 1 and resets to 0.
- Undefined: the stall_cnt port and its counter are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - REG_W = 4, NREG = 16, IDX_W = 4
  - typedef reg_idx_t
  - typedef reg_data_t
  - the one-hot load bus type shared with the write side
- One sub-module is natural: reg_scoreboard, which holds busy[15:0] with set/clear ports and the set-wins rule.
- Operand select, bypass and the output register stay in the top module.

Test Plan:
- Basic read: preload r3 = 0x5, r7 = 0xA; issue rs_a = 3, rs_b = 7, rd_en = 0 with op_ready = 1 -> next cycle op_valid = 1, op_a = 0x5, op_b = 0xA.
- RAW stall:
  - Issue rd = 2, rd_en = 1, then rs_a = 2 -> req_ready = 0 while busy[2] = 1.
  - Drive wb_load = 0x0004, wb_d = 0xC -> req_ready = 1 that cycle; next cycle op_a = 0xC via bypass.
- Backpressure: op_ready = 0 with a bundle held -> op_* stable for 5 cycles and req_ready = 0; raise op_ready -> a new bundle appears 1 cycle later.
- Set-wins: busy[4] = 1; same cycle wb_load = 0x0010 and a fire with rd = 4, rd_en = 1 -> busy[4] = 1 afterward.
- Reset mid-operation: op_valid = 1 and busy = 0x00F0, assert reset for 1 cycle -> op_valid = 0, op_* = 0, busy = 0, and the next request issues immediately.
- READER_STATS_EN: hold a RAW hazard 300 cycles with CNT_W = 8 -> stall_cnt = 255; reset -> 0.
